life_run_sequencer: RTL and testbench
=====================================

Name: life_run_sequencer

Overview:
- Controller that sequences one life_array_8x8 through a complete run: seed load, N generation steps, readback.
- Loads a 64-cell seed into the four 4x4 quadrants through the array's vali/write_enb port.
- Issues timed step pulses, then streams the four quadrants out over a valid/ready interface.
- Sits between the host/pattern source and the array; array edge inputs (n/e/s/w/nw/ne/se/sw) are tied 0 at top level and are not driven by this block.

Parameters:
- GEN_W, 16, width of generation target and counter
- PER_W, 8, width of step-period register

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin run; sampled only in IDLE
- abort  in  1  cancel run; return to IDLE
- seed  in  64  initial pattern; seed[16q+15:16q] loads quadrant selector q
- gens  in  GEN_W  generations to run
- period  in  PER_W  idle cycles between step pulses
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on normal completion
- gen_count  out  GEN_W  generations stepped in current/last run
- stable  out  1  pattern reached still life (LIFE_STILL_DETECT_EN only)
- dout  out  16  quadrant readback data
- dout_sel  out  2  quadrant index of dout
- dout_valid  out  1  readback handshake valid
- dout_ready  in  1  readback handshake ready
- arr_vali  out  16  to array vali
- arr_vali_sel  out  2  to array vali_selector
- arr_wen  out  1  to array write_enb
- arr_valo_sel  out  2  to array valo_selector
- arr_step  out  1  to array step
- arr_valo  in  16  from array valo

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; gen_count 0.
- Quadrant order is always selector 0,1,2,3 (00 TL, 01 BL, 10 TR, 11 BR).
- IDLE:
  - On start=1, register seed, gens and period; clear gen_count and stable; go to LOAD.
  - start is ignored while busy.
- LOAD: 4 consecutive cycles, one per quadrant q=0..3.
  - Drive arr_wen=1, arr_vali_sel=q, arr_vali=seed slice q.
  - arr_wen drops the cycle after q=3.
  - Next state: RUN if gens!=0, else DUMP.
- RUN:
  - Period counter waits `period` cycles, then asserts arr_step for exactly one cycle and increments gen_count.
  - With period=0, arr_step is high every cycle; in general pulses are spaced period+1 cycles apart.
  - First pulse occurs `period` cycles after entering RUN.
  - When gen_count reaches gens: go to DUMP (or CHECK, see Optional Feature).
  - gen_count never exceeds gens.
- DUMP:
  - For q=0..3: drive arr_valo_sel=q (registered); arr_valo is sampled one cycle later into dout.
  - Then assert dout_valid with dout_sel=q.
  - dout and dout_sel hold stable while dout_valid=1 and dout_ready=0.
  - Beat transfers when valid&ready; the next quadrant is selected the following cycle.
  - After beat 3 transfers: done=1 for one cycle, then IDLE.
- abort=1 in any non-IDLE state:
  - Next cycle: IDLE, arr_wen=0, arr_step=0, dout_valid=0, no done pulse.
  - gen_count retains its value.
  - abort has priority over start and over the state transition in the same cycle.
- No arr_wen and arr_step in the same cycle, ever.

Optional Feature:
- Macro: LIFE_STILL_DETECT_EN.
- Enabled:
  - A 64-bit snapshot register loads seed in LOAD.
  - After every arr_step, the FSM enters CHECK: reads quadrants 0..3 via arr_valo_sel (1-cycle latency, 5 cycles total), compares against the snapshot, and updates the snapshot.
  - All equal: stable=1, go DUMP early.
  - Otherwise: return to RUN, or go DUMP if gen_count==gens.
  - The period counter is frozen during CHECK.
- Disabled: no CHECK state, no snapshot; stable is tied 0.

Decomposition:
- Package life_pkg:
  - FSM state enum (IDLE, LOAD, RUN, CHECK, DUMP).
  - Quadrant selector constants Q_TL=0, Q_BL=1, Q_TR=2, Q_BR=3.
  - NUM_QUAD=4, QUAD_BITS=16.
- One natural sub-module, life_step_timer: period counter producing the one-cycle step pulse.
  - Inputs: enable, clear, period.

Test Plan:
- Single cell: seed=64'h1, gens=1, period=0, dout_ready=1 -> one arr_step pulse; dout 0000 for sel 0..3; gen_count=1; done pulse.
- 2x2 block across quadrants: seed quadrants TL=8000, BL=1000, TR=0008, BR=0001, gens=3 -> readback identical, gen_count=3.
  - With LIFE_STILL_DETECT_EN: gen_count=1 and stable=1.
- gens=0, seed=64'h0123_4567_89AB_CDEF -> zero arr_step pulses; dout sequence CDEF, 89AB, 4567, 0123.
- Timing: period=3, gens=4 -> arr_step pulses exactly 4 cycles apart; exactly 4 pulses; arr_wen high exactly 4 cycles in LOAD.
- Backpressure: dout_ready=0 for 5 cycles while dout_sel=2 -> dout and dout_sel unchanged, dout_valid held; sequence completes after ready returns.
- Abort and reset: abort during RUN after 2 of gens=10 -> IDLE next cycle, gen_count=2, no done.
  - Async reset asserted mid-DUMP -> all outputs 0 immediately.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types for the life run sequencer: FSM states,
// quadrant selector codes and readback beat phases.
package life_pkg;

    localparam int NUM_QUAD  = 4;
    localparam int QUAD_BITS = 16;

    localparam logic [1:0] Q_TL = 2'd0;
    localparam logic [1:0] Q_BL = 2'd1;
    localparam logic [1:0] Q_TR = 2'd2;
    localparam logic [1:0] Q_BR = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CHECK,
        DUMP
    } state_t;

    typedef enum logic [1:0] {
        PH_WAIT,
        PH_CAP,
        PH_OUT
    } dump_ph_t;

endpackage

// File: rtl/life_step_timer.sv
// Period counter: emits a one-cycle step after `period` idle
// cycles, so pulses are period+1 cycles apart while enabled.
module life_step_timer #(
    parameter int PER_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [PER_W-1:0] period,
    output logic             step
);

    logic [PER_W-1:0] cnt;

    assign step = enable && (cnt == period);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= step ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/life_run_sequencer.sv
// Runs a life_array_8x8 through seed load, N steps and readback.
// Define LIFE_STILL_DETECT_EN to stop early on a still life.
module life_run_sequencer
    import life_pkg::*;
#(
    parameter int GEN_W = 16,
    parameter int PER_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [63:0]      seed,
    input  logic [GEN_W-1:0] gens,
    input  logic [PER_W-1:0] period,
    output logic             busy,
    output logic             done,
    output logic [GEN_W-1:0] gen_count,
    output logic             stable,
    output logic [15:0]      dout,
    output logic [1:0]       dout_sel,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [15:0]      arr_vali,
    output logic [1:0]       arr_vali_sel,
    output logic             arr_wen,
    output logic [1:0]       arr_valo_sel,
    output logic             arr_step,
    input  logic [15:0]      arr_valo
);

    state_t   state, state_n;
    dump_ph_t phase;

    logic [1:0]                    q;
    logic [NUM_QUAD*QUAD_BITS-1:0] seed_r;
    logic [GEN_W-1:0]              gens_r;
    logic [GEN_W-1:0]              gc_inc;
    logic [PER_W-1:0]              per_r;
    logic [1:0]                    valo_sel_r;
    logic                          step;
    logic                          last_beat;

    assign gc_inc    = gen_count + 1'b1;
    assign last_beat = (state == DUMP) && (phase == PH_OUT)
                    && dout_ready && (q == Q_BR);

`ifdef LIFE_STILL_DETECT_EN
    logic [NUM_QUAD*QUAD_BITS-1:0] snap;
    logic [2:0]                    idx;
    logic [1:0]                    cq;
    logic                          diff;
    logic                          all_eq;
    logic                          stable_r;

    // Read data trails the selector by one cycle.
    assign cq     = idx[1:0] - 2'd1;
    assign all_eq = !diff && (arr_valo == snap[{cq, 4'd0} +: QUAD_BITS]);
    assign stable = stable_r;
`else
    assign stable = 1'b0;
`endif

    life_step_timer #(
        .PER_W (PER_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (state == RUN),
        .clear  (state == LOAD),
        .period (per_r),
        .step   (step)
    );

    assign busy         = (state != IDLE);
    assign arr_wen      = (state == LOAD);
    assign arr_vali_sel = arr_wen ? q : Q_TL;
    assign arr_vali     = arr_wen ? seed_r[{q, 4'd0} +: QUAD_BITS] : '0;
    assign arr_step     = step;
    assign arr_valo_sel = valo_sel_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (start) state_n = LOAD;
            LOAD:  if (q == Q_BR) state_n = (gens_r != '0) ? RUN : DUMP;
            RUN: begin
                if (step) begin
`ifdef LIFE_STILL_DETECT_EN
                    state_n = CHECK;
`else
                    if (gc_inc == gens_r) state_n = DUMP;
`endif
                end
            end
            CHECK: begin
`ifdef LIFE_STILL_DETECT_EN
                if (idx == 3'd4)
                    state_n = (all_eq || gen_count == gens_r) ? DUMP : RUN;
`else
                state_n = IDLE;
`endif
            end
            DUMP:    if (last_beat) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q          <= Q_TL;
            phase      <= PH_WAIT;
            seed_r     <= '0;
            gens_r     <= '0;
            per_r      <= '0;
            gen_count  <= '0;
            valo_sel_r <= Q_TL;
            dout       <= '0;
            dout_sel   <= Q_TL;
            dout_valid <= 1'b0;
            done       <= 1'b0;
`ifdef LIFE_STILL_DETECT_EN
            snap       <= '0;
            idx        <= '0;
            diff       <= 1'b0;
            stable_r   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        seed_r    <= seed;
                        gens_r    <= gens;
                        per_r     <= period;
                        gen_count <= '0;
                        q         <= Q_TL;
`ifdef LIFE_STILL_DETECT_EN
                        stable_r  <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    q <= q + 2'd1;
`ifdef LIFE_STILL_DETECT_EN
                    snap <= seed_r;
`endif
                end
                RUN: begin
                    if (step) begin
                        gen_count <= gc_inc;
`ifdef LIFE_STILL_DETECT_EN
                        idx        <= '0;
                        diff       <= 1'b0;
                        valo_sel_r <= Q_TL;
`endif
                    end
                end
                CHECK: begin
`ifdef LIFE_STILL_DETECT_EN
                    idx        <= idx + 3'd1;
                    valo_sel_r <= (idx < 3'd3) ? idx[1:0] + 2'd1 : Q_TL;
                    if (idx != 3'd0) begin
                        if (arr_valo != snap[{cq, 4'd0} +: QUAD_BITS])
                            diff <= 1'b1;
                        snap[{cq, 4'd0} +: QUAD_BITS] <= arr_valo;
                    end
                    if (idx == 3'd4 && all_eq) stable_r <= 1'b1;
`endif
                end
                DUMP: begin
                    unique case (phase)
                        PH_WAIT: phase <= PH_CAP;
                        PH_CAP: begin
                            dout       <= arr_valo;
                            dout_sel   <= q;
                            dout_valid <= 1'b1;
                            phase      <= PH_OUT;
                        end
                        PH_OUT: begin
                            if (dout_ready) begin
                                dout_valid <= 1'b0;
                                q          <= q + 2'd1;
                                valo_sel_r <= q + 2'd1;
                                phase      <= PH_WAIT;
                                done       <= (q == Q_BR) && !abort;
                            end
                        end
                        default: phase <= PH_WAIT;
                    endcase
                end
                default: ;
            endcase
            if (state_n == DUMP && state != DUMP) begin
                q          <= Q_TL;
                phase      <= PH_WAIT;
                valo_sel_r <= Q_TL;
            end
            if (abort && state != IDLE) dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_life_run_sequencer.sv
// Randomized scoreboard bench for life_run_sequencer with a
// behavioural 8x8 life array and a generation-level reference model.
module tb_life_run_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [63:0] seed;
    logic [15:0] gens;
    logic [7:0]  period;
    logic        busy;
    logic        done;
    logic [15:0] gen_count;
    logic        stable;
    logic [15:0] dout;
    logic [1:0]  dout_sel;
    logic        dout_valid;
    logic        dout_ready;
    logic [15:0] arr_vali;
    logic [1:0]  arr_vali_sel;
    logic        arr_wen;
    logic [1:0]  arr_valo_sel;
    logic        arr_step;
    logic [15:0] arr_valo;

    life_run_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .seed         (seed),
        .gens         (gens),
        .period       (period),
        .busy         (busy),
        .done         (done),
        .gen_count    (gen_count),
        .stable       (stable),
        .dout         (dout),
        .dout_sel     (dout_sel),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .arr_vali     (arr_vali),
        .arr_vali_sel (arr_vali_sel),
        .arr_wen      (arr_wen),
        .arr_valo_sel (arr_valo_sel),
        .arr_step     (arr_step),
        .arr_valo     (arr_valo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef LIFE_STILL_DETECT_EN
    localparam int CHK_GAP = 5;
`else
    localparam int CHK_GAP = 0;
`endif

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input bit ok,
                       input longint act, input longint exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Cell (r,c) of the 8x8 board inside the 64-bit seed layout.
    function automatic int pos(input int r, input int c);
        return 16 * ((c / 4) * 2 + r / 4) + 4 * (c % 4) + (r % 4);
    endfunction

    function automatic logic [63:0] life_next(input logic [63:0] g);
        logic [63:0] nx;
        int n;
        nx = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8
                            && c + dc >= 0 && c + dc < 8)
                            n += int'(g[pos(r + dr, c + dc)]);
                nx[pos(r, c)] = (n == 3) || (n == 2 && g[pos(r, c)]);
            end
        end
        return nx;
    endfunction

    logic [63:0] grid;
    always @(posedge clk) begin
        if (arr_wen) grid[int'(arr_vali_sel) * 16 +: 16] <= arr_vali;
        if (arr_step) grid <= life_next(grid);
        arr_valo <= grid[int'(arr_valo_sel) * 16 +: 16];
    end

    function automatic logic [63:0] outs();
        return {4'h0, busy, done, gen_count, stable, dout, dout_sel,
                dout_valid, arr_vali, arr_vali_sel, arr_wen,
                arr_valo_sel, arr_step};
    endfunction

    logic [17:0] exp_q[$];
    int cyc = 0;
    int wen_total = 0;
    int step_total = 0;
    int done_total = 0;
    int overlap_total = 0;
    int last_wen = -100;
    int prev_step = -100;
    int per_exp = 0;

    initial begin
        logic [17:0] e;
        int exp_c;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                if (arr_wen) begin
                    wen_total++;
                    last_wen = cyc;
                end
                if (arr_wen && arr_step) overlap_total++;
                if (done) done_total++;
                if (arr_step) begin
                    if (last_wen > prev_step) exp_c = last_wen + 1 + per_exp;
                    else exp_c = prev_step + per_exp + 1 + CHK_GAP;
                    chk("step_time", cyc == exp_c, cyc, exp_c);
                    step_total++;
                    prev_step = cyc;
                end
                if (dout_valid && dout_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("beat_unexpected", 1'b0, {dout_sel, dout}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", {dout_sel, dout} == e, {dout_sel, dout}, e);
                    end
                end
            end
        end
    end

    // mode: 0 ready high, 1 random ready, 2 stall on quadrant 2,
    // 3 async reset once readback is presented. ab>0 aborts after ab steps.
    task automatic run_case(input logic [63:0] s, input int g, input int p,
                            input int mode, input int ab);
        logic [63:0] gm;
        logic [63:0] nx;
        logic [15:0] bp_d;
        int n, w0, s0, d0, bp_n;
        bit st, bp_seen, fin;
        gm = s;
        n = 0;
        st = 1'b0;
        while (n < g && !st) begin
            nx = life_next(gm);
            n++;
`ifdef LIFE_STILL_DETECT_EN
            st = (nx == gm);
`endif
            gm = nx;
        end
        if (ab == 0 && mode != 3)
            for (int q = 0; q < 4; q++)
                exp_q.push_back({2'(q), gm[q * 16 +: 16]});
        w0 = wen_total;
        s0 = step_total;
        d0 = done_total;
        bp_n = 0;
        bp_d = '0;
        bp_seen = 1'b0;
        fin = 1'b0;
        per_exp = p;
        dout_ready = (mode == 0 || mode == 2);
        seed = s;
        gens = 16'(g);
        period = 8'(p);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 3000 && !fin; i++) begin
            if (ab > 0 && busy && step_total - s0 == ab && !arr_step) begin
                abort = 1'b1;
                @(posedge clk);
                #1 abort = 1'b0;
                chk("abort_idle", {busy, arr_wen, arr_step, dout_valid} == 4'b0,
                    {busy, arr_wen, arr_step, dout_valid}, 0);
                chk("abort_gen", gen_count == 16'(ab), gen_count, ab);
                repeat (4) @(posedge clk);
                #1;
                chk("abort_no_done", done_total == d0, done_total - d0, 0);
                fin = 1'b1;
            end else if (mode == 3 && dout_valid) begin
                #2 reset = 1'b0;
                #1 chk("async_reset", outs() == 64'h0, outs(), 0);
                #2 reset = 1'b1;
                fin = 1'b1;
            end else if (done_total != d0) begin
                repeat (3) @(posedge clk);
                #1;
                chk("done_once", done_total - d0 == 1, done_total - d0, 1);
                chk("gen_count", gen_count == 16'(n), gen_count, n);
                chk("stable", stable == st, stable, st);
                chk("step_count", step_total - s0 == n, step_total - s0, n);
                chk("wen_cycles", wen_total - w0 == 4, wen_total - w0, 4);
                chk("beats_left", exp_q.size() == 0, exp_q.size(), 0);
                chk("idle_after", busy == 1'b0, busy, 0);
                chk("no_overlap", overlap_total == 0, overlap_total, 0);
                if (mode == 2) chk("bp_seen", bp_seen, bp_seen, 1);
                fin = 1'b1;
            end else begin
                if (mode == 1) begin
                    dout_ready = 1'($urandom_range(0, 1));
                end else if (mode == 2) begin
                    if (bp_n > 0) begin
                        chk("bp_hold", dout_valid && dout == bp_d && dout_sel == 2'd2,
                            {dout_valid, dout_sel, dout}, {1'b1, 2'd2, bp_d});
                        bp_n--;
                        if (bp_n == 0) dout_ready = 1'b1;
                    end else if (!bp_seen && dout_valid && dout_sel == 2'd2) begin
                        bp_seen = 1'b1;
                        bp_d = dout;
                        bp_n = 5;
                        dout_ready = 1'b0;
                    end
                end
                @(posedge clk);
                #1;
            end
        end
        if (!fin) begin
            chk("timeout", 1'b0, 3000, 0);
            reset = 1'b0;
            #2 reset = 1'b1;
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        seed = '0;
        gens = '0;
        period = '0;
        dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3 chk("reset_outs", outs() == 64'h0, outs(), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_case(64'h1, 1, 0, 0, 0);
        run_case(64'h0001_0008_1000_8000, 3, 1, 0, 0);
        run_case(64'h0123_4567_89AB_CDEF, 0, 2, 0, 0);
        run_case({$urandom, $urandom}, 4, 3, 0, 0);
        run_case({$urandom, $urandom}, 2, 1, 2, 0);
        run_case(64'h0000_0000_0000_0222, 10, 2, 1, 2);
        for (int k = 0; k < 8; k++)
            run_case({$urandom, $urandom}, int'($urandom_range(0, 5)),
                     int'($urandom_range(0, 3)), 1, 0);
        run_case({$urandom, $urandom}, 2, 1, 3, 0);
        run_case(64'h0001_0008_1000_8000, 2, 0, 0, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
